vec_alu_sequencer: RTL
======================

# vec_alu_sequencer

Sequences single vector instructions through the 16-lane × 32-bit vector ALU, which has a registered output and supports add or multiply. It accepts one command per valid/ready handshake and reads two 512-bit source registers from the vector register file. It drives the ALU for one enabled cycle, then writes the low result (sum or product low word) and, optionally, the high result (carry or product high word) back to the register file. It sits between the instruction decode stage and the ALU/register-file pair, and is the only writer of the register file during vector execution.

## Interface
- DATA_W, 512: vector width (LANES × 32).
- LANES, 16: 32-bit lanes per vector (informational; the ALU consumes the full DATA_W bus).
- ADDR_W, 2: register-file index width (4 vector registers).
- CNT_W, 16: width of the completed-instruction counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  1  0 = add, 1 = multiply.
- cmd_src1, cmd_src2  in  ADDR_W  source register indices.
- cmd_dst_lo, cmd_dst_hi  in  ADDR_W  destination indices for the low and high results.
- cmd_wr_hi  in  1  1 = also write the high result.
- rf_raddr1, rf_raddr2  out  ADDR_W  register-file read addresses (combinational read).
- rf_rdata1, rf_rdata2  in  DATA_W  read data.
- rf_we  out  1  register-file write strobe.
- rf_waddr  out  ADDR_W  write address.
- rf_wdata  out  DATA_W  write data.
- alu_enable  out  1  ALU enable.
- alu_op  out  1  ALU opcode.
- alu_a1, alu_a2  out  DATA_W  ALU operands.
- alu_a3, alu_a4  in  DATA_W  ALU registered low/high results.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on the final writeback of a command.
- instr_count  out  CNT_W  number of completed commands; wraps modulo 2^CNT_W.

## Operation
- FSM states: IDLE, EXEC, WB_LO, WB_HI.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready, latch op, src1, src2, dst_lo, dst_hi and wr_hi, then go to EXEC.
- EXEC:
  - rf_raddr1/2 = latched src1/src2.
  - alu_a1 = rf_rdata1, alu_a2 = rf_rdata2.
  - alu_op = latched op, alu_enable = 1.
  - Next state is WB_LO.
- WB_LO:
  - rf_we = 1, rf_waddr = dst_lo, rf_wdata = alu_a3.
  - If wr_hi = 1, go to WB_HI.
  - Otherwise assert done, increment instr_count and go to IDLE.
- WB_HI:
  - rf_we = 1, rf_waddr = dst_hi, rf_wdata = alu_a4.
  - Assert done, increment instr_count and go to IDLE.
- alu_enable is 0 outside EXEC, so alu_a4 holds stable through WB_HI.
- Sources are read only in EXEC. A destination equal to a source is therefore safe.
- If dst_lo == dst_hi with wr_hi = 1, the high result is written last and is the final value.
- Outside EXEC:
  - alu_a1 and alu_a2 are driven to 0.
  - rf_raddr1 and rf_raddr2 hold the latched indices.
- rf_wdata is 0 when rf_we = 0.
- cmd_* inputs are ignored in every state except IDLE.

## Timing
- Handshake at edge T (IDLE). EXEC is cycle T+1, WB_LO is T+2, WB_HI is T+3.
- Done timing:
  - wr_hi = 1: done at T+3, cmd_ready at T+4; throughput 1 command per 4 cycles.
  - wr_hi = 0: done at T+2, cmd_ready at T+3; 1 command per 3 cycles.
- cmd_ready is a decode of state (IDLE), with no combinational path from cmd_valid. It is 0 during the reset cycle.
- While rst is high, and at the first edge after it:
  - state = IDLE, instr_count = 0, latched fields = 0.
  - done, rf_we, alu_enable and busy are 0; all data outputs are 0.
- Reset mid-operation in any state: abort immediately. No further rf_we and no done pulse for the aborted command; instr_count is cleared.
- instr_count updates on the same edge that ends the done cycle. At all-ones it wraps to 0.

## Structure
- Shared package vec_pkg holds:
  - OP_ADD = 1'b0 and OP_MUL = 1'b1;
  - the seq_state_t enum (IDLE, EXEC, WB_LO, WB_HI);
  - the DATA_W and ADDR_W defaults.
- The block is a single flat module with no sub-module. The ALU and register file are instantiated beside it by the vector-unit top level.

## Test plan
- Add with carry: src1 lanes = 0xFFFFFFFF, src2 lanes = 0x00000001, wr_hi = 1, dst_lo = 2, dst_hi = 3. Required: reg2 lanes = 0x00000000, reg3 lanes = 0x00000001, done at T+3, instr_count = 1.
- Multiply: src lanes = 0x00010000 × 0x00010000, wr_hi = 1. Required: low lanes = 0x00000000, high lanes = 0x00000001. Lane 15 = 0x0000FFFF × 0x00000003 gives low 0x0002FFFD, high 0.
- Back-to-back: cmd_valid held high with two commands, the first with wr_hi = 0. Required: second accepted exactly 3 cycles after the first; rf_we pulses at T+2 and T+5.
- Same destination: dst_lo = dst_hi = 1, src lanes 0x80000000 + 0x80000000. Required: reg1 final = 0x00000001 per lane, two rf_we cycles.
- Reset in WB_LO: rst asserted for 1 cycle. Required: no rf_we in the following cycle, no done, instr_count = 0, cmd_ready = 1 one cycle after rst deasserts.
- Counter wrap: 65536 commands completed. Required: instr_count = 0, and equals 1 after the next done.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared definitions for the vector execution unit: opcodes, sequencer
// state encoding and default bus widths.
package vec_pkg;

    localparam int DATA_W = 512;  // LANES x 32-bit vector
    localparam int LANES  = 16;   // 32-bit lanes per vector
    localparam int ADDR_W = 2;    // four vector registers
    localparam int CNT_W  = 16;   // completed-instruction counter width

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WB_LO,
        WB_HI
    } seq_state_t;

endpackage

// File: rtl/vec_alu_sequencer.sv
// Vector ALU sequencer: accepts one instruction per handshake, fires the
// registered ALU for a single cycle, then writes the low and optionally the
// high result back to the vector register file.
module vec_alu_sequencer #(
    parameter int DATA_W = vec_pkg::DATA_W,
    parameter int ADDR_W = vec_pkg::ADDR_W,
    parameter int CNT_W  = vec_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [ADDR_W-1:0] cmd_src1,
    input  logic [ADDR_W-1:0] cmd_src2,
    input  logic [ADDR_W-1:0] cmd_dst_lo,
    input  logic [ADDR_W-1:0] cmd_dst_hi,
    input  logic              cmd_wr_hi,

    output logic [ADDR_W-1:0] rf_raddr1,
    output logic [ADDR_W-1:0] rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,

    output logic              alu_enable,
    output logic              alu_op,
    output logic [DATA_W-1:0] alu_a1,
    output logic [DATA_W-1:0] alu_a2,
    input  logic [DATA_W-1:0] alu_a3,
    input  logic [DATA_W-1:0] alu_a4,

    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  instr_count
);

    import vec_pkg::*;

    seq_state_t        state_q, state_d;

    // Command fields captured at the handshake; cmd_* is ignored afterwards.
    logic              op_q;
    logic [ADDR_W-1:0] src1_q;
    logic [ADDR_W-1:0] src2_q;
    logic [ADDR_W-1:0] dst_lo_q;
    logic [ADDR_W-1:0] dst_hi_q;
    logic              wr_hi_q;
    logic [CNT_W-1:0]  cnt_q;

    // State decodes shared by the register update and the output drive.
    logic accept;
    logic in_exec;
    logic in_wb_lo;
    logic in_wb_hi;
    logic fsm_done;

    // Next-state logic and per-state strobes.
    // NOTE: every always_comb output gets a default before the case so no
    // path leaves a signal unassigned and a latch can never be inferred.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        in_exec  = 1'b0;
        in_wb_lo = 1'b0;
        in_wb_hi = 1'b0;
        fsm_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                in_exec = 1'b1;
                state_d = WB_LO;
            end
            WB_LO: begin
                in_wb_lo = 1'b1;
                if (wr_hi_q) begin
                    state_d = WB_HI;
                end else begin
                    fsm_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            WB_HI: begin
                in_wb_hi = 1'b1;
                fsm_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched command fields and the completion counter.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_ADD;
            src1_q   <= '0;
            src2_q   <= '0;
            dst_lo_q <= '0;
            dst_hi_q <= '0;
            wr_hi_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q     <= cmd_op;
                src1_q   <= cmd_src1;
                src2_q   <= cmd_src2;
                dst_lo_q <= cmd_dst_lo;
                dst_hi_q <= cmd_dst_hi;
                wr_hi_q  <= cmd_wr_hi;
            end
            if (fsm_done) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Output drive; reset masks every strobe and data bus so an aborted
    // command cannot write back or signal completion in the reset cycle.
    always_comb begin
        cmd_ready   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        alu_enable  = 1'b0;
        alu_op      = OP_ADD;
        alu_a1      = '0;
        alu_a2      = '0;
        rf_raddr1   = '0;
        rf_raddr2   = '0;
        rf_we       = 1'b0;
        rf_waddr    = '0;
        rf_wdata    = '0;
        instr_count = '0;
        if (!rst) begin
            cmd_ready   = (state_q == IDLE);
            busy        = (state_q != IDLE);
            done        = fsm_done;
            instr_count = cnt_q;
            rf_raddr1   = src1_q;
            rf_raddr2   = src2_q;
            alu_op      = op_q;
            rf_waddr    = dst_lo_q;
            if (in_exec) begin
                alu_enable = 1'b1;
                alu_a1     = rf_rdata1;
                alu_a2     = rf_rdata2;
            end
            if (in_wb_lo) begin
                rf_we    = 1'b1;
                rf_wdata = alu_a3;
            end
            if (in_wb_hi) begin
                rf_we    = 1'b1;
                rf_waddr = dst_hi_q;
                rf_wdata = alu_a4;
            end
        end
    end

endmodule
